// File: rtl/psw_digit_store.sv
// psw_digit_store: keypad release detector plus password memory and entry
// buffer, both held as left-shifting BCD digit registers. Status flags are
// decoded purely from registered state for the downstream control unit.
module psw_digit_store #(
   parameter int          MAX_LEN    = 8,
   parameter int          MIN_LEN    = 4,
   parameter int          MASTER_LEN = 6,
   parameter logic [31:0] MASTER_PSW = 32'h00314159
) (
   input  logic       clk_i,
   input  logic       nreset_i,
   input  logic [9:0] key_i,
   input  logic       mem_rst_i,
   input  logic       mem_sl_i,
   input  logic       buff_rst_i,
   input  logic       buff_sl_i,
   output logic       input_valid_o,
   output logic       same_o,
   output logic       master_same_o,
   output logic       mem_limit_o,
   output logic       buff_limit_o,
   output logic [3:0] digit_o
);

   localparam int             W          = MAX_LEN * 4;
   localparam logic [3:0]     MAX_LEN_C  = 4'(MAX_LEN);
   localparam logic [3:0]     MIN_LEN_C  = 4'(MIN_LEN);
   localparam logic [3:0]     MASTER_C   = 4'(MASTER_LEN);
   localparam logic [W-1:0]   MASTER_EXT = W'(MASTER_PSW);

   logic [9:0]   key_q;
   logic [3:0]   digit_q;
   logic         valid_q;
   logic [3:0]   key_idx;
   logic         accept;
   logic [W-1:0] mem_q;
   logic [W-1:0] buff_q;
   logic [3:0]   mem_len;
   logic [3:0]   buff_len;

   // Encode the single set bit of the previous key sample into a digit.
   always_comb begin
      // NOTE: default assignment first so no path leaves key_idx unassigned (no latch).
      key_idx = '0;
      for (int i = 0; i < 10; i++) begin
         if (key_q[i]) key_idx = 4'(i);
      end
   end

   // A digit counts only on release of exactly one key; chords and holds never pulse.
   assign accept = (key_i == 10'd0) && $onehot(key_q);

   // Track the key history, latch the released digit and raise the one-cycle pulse.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         key_q   <= '0;
         digit_q <= '0;
         valid_q <= 1'b0;
      end else begin
         // NOTE: non-blocking so every register here samples pre-edge values.
         key_q   <= key_i;
         valid_q <= accept;
         if (accept) digit_q <= key_idx;
      end
   end

   // Enrolled password register: clear beats shift, shift stops at capacity.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         // NOTE: the digit registers are reset like any flop; unused high digits must read 0.
         mem_q   <= '0;
         mem_len <= '0;
      end else if (mem_rst_i) begin
         mem_q   <= '0;
         mem_len <= '0;
      end else if (mem_sl_i && (mem_len < MAX_LEN_C)) begin
         mem_q   <= {mem_q[W-5:0], digit_q};
         mem_len <= mem_len + 4'd1;
      end
   end

   // Entered attempt register: same command semantics as the memory.
   always_ff @(posedge clk_i or negedge nreset_i) begin
      if (!nreset_i) begin
         buff_q   <= '0;
         buff_len <= '0;
      end else if (buff_rst_i) begin
         buff_q   <= '0;
         buff_len <= '0;
      end else if (buff_sl_i && (buff_len < MAX_LEN_C)) begin
         buff_q   <= {buff_q[W-5:0], digit_q};
         buff_len <= buff_len + 4'd1;
      end
   end

   // Status decoded from registers only, settled well before the negedge sample.
   always_comb begin
      mem_limit_o   = (mem_len == MAX_LEN_C);
      buff_limit_o  = (buff_len == MAX_LEN_C);
      same_o        = (buff_len == mem_len) && (buff_q == mem_q) && (mem_len >= MIN_LEN_C);
      master_same_o = (buff_len == MASTER_C) && (buff_q == MASTER_EXT);
   end

   assign input_valid_o = valid_q;
   assign digit_o       = digit_q;

endmodule
